// File: rtl/i2c_pad_pkg.sv
// Shared helpers for the I2C pad front-end: select width, pin mapping and filter counter size.
package i2c_pad_pkg;

  localparam int unsigned FiltCntW = 4;

  function automatic int unsigned calc_selw(input int unsigned channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

  function automatic int unsigned scl_pin(input int unsigned pin_base, input int unsigned k);
    return pin_base + 2 * k;
  endfunction

  function automatic int unsigned sda_pin(input int unsigned pin_base, input int unsigned k);
    return pin_base + 2 * k + 1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a stability filter; idles high so a reset bus reads released.
module i2c_line_filter
  import i2c_pad_pkg::*;
#(
  parameter int unsigned FilterLen = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic                sync1_q, sync2_q;
  logic                filt_q, filt_d;
  logic [FiltCntW-1:0] cnt_q, cnt_d;

  // Count cycles the synchronised value disagrees with the filtered one; any agreement restarts.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == FiltCntW'(FilterLen - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + FiltCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o = filt_q;

endmodule

// File: rtl/i2c_multi_pad.sv
// Multi-bus I2C pad front-end: routes one master to a selectable SCL/SDA pin pair and tracks
// START/STOP/busy on every bus from glitch-filtered inputs.
module i2c_multi_pad
  import i2c_pad_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned PIN_BASE   = 8,
  parameter int unsigned IO_WIDTH   = 38,
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned OPEN_DRAIN = 1,
  parameter int unsigned SELW       = calc_selw(CHANNELS)
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [SELW-1:0]     sel_i,
  input  logic                m_scl_o,
  input  logic                m_scl_oen,
  input  logic                m_sda_o,
  input  logic                m_sda_oen,
  output logic                m_scl_i,
  output logic                m_sda_i,
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out,
  output logic [IO_WIDTH-1:0] io_oeb,
  output logic [SELW-1:0]     active_o,
  output logic                sel_pending_o,
  output logic [CHANNELS-1:0] bus_busy_o,
  output logic [CHANNELS-1:0] start_o,
  output logic [CHANNELS-1:0] stop_o
);

  logic [CHANNELS-1:0] scl_f, sda_f;
  logic [CHANNELS-1:0] scl_prev_q, sda_prev_q;
  logic [CHANNELS-1:0] busy_q, busy_d, start_q, start_d, stop_q, stop_d;
  logic [SELW-1:0]     active_q, active_d;
  logic                sel_valid, sel_pending, m_drv_low;
  logic                unused_io;

  // Pins outside the channel range are never read.
  assign unused_io = ^io_in;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    i2c_line_filter #(
      .FilterLen(FILTER_LEN)
    ) u_scl_filt (
      .clk_i (wb_clk_i),
      .rst_ni(wb_rst_ni),
      .d_i   (io_in[scl_pin(PIN_BASE, k)]),
      .q_o   (scl_f[k])
    );

    i2c_line_filter #(
      .FilterLen(FILTER_LEN)
    ) u_sda_filt (
      .clk_i (wb_clk_i),
      .rst_ni(wb_rst_ni),
      .d_i   (io_in[sda_pin(PIN_BASE, k)]),
      .q_o   (sda_f[k])
    );
  end

  // SCL must be high on both sides of the SDA edge, so simultaneous changes never qualify.
  always_comb begin
    start_d = scl_prev_q & scl_f & sda_prev_q & ~sda_f;
    stop_d  = scl_prev_q & scl_f & ~sda_prev_q & sda_f;
    busy_d  = (busy_q | start_d) & ~stop_d;
  end

  assign sel_valid   = 32'(sel_i) < CHANNELS;
  assign sel_pending = sel_valid && (sel_i != active_q);
  assign m_drv_low   = (m_scl_oen & ~m_scl_o) | (m_sda_oen & ~m_sda_o);

  always_comb begin
    active_d = active_q;
    if (sel_pending && !busy_q[active_q] && !m_drv_low) begin
      active_d = sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      scl_prev_q <= '1;
      sda_prev_q <= '1;
      busy_q     <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      active_q   <= '0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      busy_q     <= busy_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      active_q   <= active_d;
    end
  end

  // Gated by reset so every pin lets go the instant reset asserts.
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    if (wb_rst_ni) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (SELW'(k) == active_q) begin
          if (OPEN_DRAIN != 0) begin
            io_oeb[scl_pin(PIN_BASE, k)] = ~(m_scl_oen & ~m_scl_o);
            io_oeb[sda_pin(PIN_BASE, k)] = ~(m_sda_oen & ~m_sda_o);
          end else begin
            io_out[scl_pin(PIN_BASE, k)] = m_scl_o;
            io_out[sda_pin(PIN_BASE, k)] = m_sda_o;
            io_oeb[scl_pin(PIN_BASE, k)] = ~m_scl_oen;
            io_oeb[sda_pin(PIN_BASE, k)] = ~m_sda_oen;
          end
        end
      end
    end
  end

  assign m_scl_i       = scl_f[active_q];
  assign m_sda_i       = sda_f[active_q];
  assign active_o      = active_q;
  assign sel_pending_o = sel_pending;
  assign bus_busy_o    = busy_q;
  assign start_o       = start_q;
  assign stop_o        = stop_q;

endmodule

// File: tb/tb_i2c_multi_pad.sv
// Scoreboard bench for i2c_multi_pad: stimulus queues cycle-stamped expectations, a negedge
// monitor pops and compares them against an open-drain and a push-pull instance.
module tb_i2c_multi_pad;

  localparam int unsigned IoW = 38;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [0:0]     sel = 1'b0;
  logic           m_scl_o = 1'b1, m_scl_oen = 1'b0, m_sda_o = 1'b1, m_sda_oen = 1'b0;
  logic [IoW-1:0] io_in = '1;

  logic           m_scl_i, m_sda_i, sel_pending;
  logic [IoW-1:0] io_out, io_oeb;
  logic [0:0]     active;
  logic [1:0]     busy, start, stop;

  logic           pp_m_scl_i, pp_m_sda_i, pp_sel_pending;
  logic [IoW-1:0] pp_io_out, pp_io_oeb;
  logic [0:0]     pp_active;
  logic [1:0]     pp_busy, pp_start, pp_stop;

  i2c_multi_pad #(.CHANNELS(2), .PIN_BASE(8), .IO_WIDTH(IoW), .FILTER_LEN(3), .OPEN_DRAIN(1))
  dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .sel_i(sel),
    .m_scl_o(m_scl_o), .m_scl_oen(m_scl_oen), .m_sda_o(m_sda_o), .m_sda_oen(m_sda_oen),
    .m_scl_i(m_scl_i), .m_sda_i(m_sda_i), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .active_o(active), .sel_pending_o(sel_pending), .bus_busy_o(busy), .start_o(start),
    .stop_o(stop)
  );

  i2c_multi_pad #(.CHANNELS(2), .PIN_BASE(8), .IO_WIDTH(IoW), .FILTER_LEN(3), .OPEN_DRAIN(0))
  dut_pp (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .sel_i(sel),
    .m_scl_o(m_scl_o), .m_scl_oen(m_scl_oen), .m_sda_o(m_sda_o), .m_sda_oen(m_sda_oen),
    .m_scl_i(pp_m_scl_i), .m_sda_i(pp_m_sda_i), .io_in(io_in), .io_out(pp_io_out),
    .io_oeb(pp_io_oeb), .active_o(pp_active), .sel_pending_o(pp_sel_pending),
    .bus_busy_o(pp_busy), .start_o(pp_start), .stop_o(pp_stop)
  );

  always #5 clk = ~clk;

  typedef enum int {
    OOeb, OOut, OPpOeb, OPpOut, OOebAll, OOutAny, OMscl, OMsda, OBusy, OStart, OStop,
    OActive, OPend
  } sig_e;

  typedef struct {
    string name;
    sig_e  sig;
    int    idx;
    int    exp_v;
    int    due;
  } chk_t;

  chk_t sb[$];
  chk_t cur;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   got;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int observe(input sig_e s, input int idx);
    case (s)
      OOeb:    return int'(io_oeb[idx]);
      OOut:    return int'(io_out[idx]);
      OPpOeb:  return int'(pp_io_oeb[idx]);
      OPpOut:  return int'(pp_io_out[idx]);
      OOebAll: return int'(&io_oeb);
      OOutAny: return int'(|io_out);
      OMscl:   return int'(m_scl_i);
      OMsda:   return int'(m_sda_i);
      OBusy:   return int'(busy[idx]);
      OStart:  return int'(start[idx]);
      OStop:   return int'(stop[idx]);
      OActive: return int'(active);
      OPend:   return int'(sel_pending);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      n_chk++;
      if (cur.due != cyc) begin
        n_fail++;
        $display("FAIL %s: not sampled at cycle %0d (now %0d)", cur.name, cur.due, cyc);
      end else begin
        got = observe(cur.sig, cur.idx);
        if (got != cur.exp_v) begin
          n_fail++;
          $display("FAIL %s: got %0d, expected %0d (cycle %0d)", cur.name, got, cur.exp_v,
                   cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string name, input sig_e s, input int idx, input int exp_v,
                           input int d);
    sb.push_back('{name, s, idx, exp_v, cyc + d});
  endtask

  initial begin
    // Reset values
    tick(2);
    expect_at("rst_oeb_all", OOebAll, 0, 1, 0);
    expect_at("rst_out_any", OOutAny, 0, 0, 0);
    expect_at("rst_mscl", OMscl, 0, 1, 0);
    expect_at("rst_msda", OMsda, 0, 1, 0);
    expect_at("rst_busy0", OBusy, 0, 0, 0);
    expect_at("rst_busy1", OBusy, 1, 0, 0);
    expect_at("rst_active", OActive, 0, 0, 0);
    rst_n = 1'b1;
    tick(3);

    // Two-cycle glitch on ch0 SDA is rejected
    io_in[9] = 1'b0;
    tick(2);
    io_in[9] = 1'b1;
    expect_at("glitch_msda_a", OMsda, 0, 1, 3);
    expect_at("glitch_msda_b", OMsda, 0, 1, 4);
    expect_at("glitch_start0", OStart, 0, 0, 4);
    tick(6);

    // Three-cycle low passes after 2+3 cycles and forms a START then STOP on ch0
    io_in[9] = 1'b0;
    expect_at("filt_msda_d4", OMsda, 0, 1, 4);
    expect_at("filt_msda_d5", OMsda, 0, 0, 5);
    expect_at("filt_start0_d6", OStart, 0, 1, 6);
    expect_at("filt_busy0_d6", OBusy, 0, 1, 6);
    expect_at("filt_start0_d7", OStart, 0, 0, 7);
    expect_at("filt_msda_d7", OMsda, 0, 0, 7);
    expect_at("filt_msda_d8", OMsda, 0, 1, 8);
    expect_at("filt_stop0_d9", OStop, 0, 1, 9);
    expect_at("filt_busy0_d9", OBusy, 0, 0, 9);
    expect_at("filt_stop0_d10", OStop, 0, 0, 10);
    tick(3);
    io_in[9] = 1'b1;
    tick(9);

    // Output drive, channel 0
    m_sda_oen = 1'b1;
    m_sda_o   = 1'b0;
    expect_at("od_low_oeb9", OOeb, 9, 0, 0);
    expect_at("od_low_out9", OOut, 9, 0, 0);
    expect_at("pp_low_oeb9", OPpOeb, 9, 0, 0);
    expect_at("pp_low_out9", OPpOut, 9, 0, 0);
    expect_at("od_inactive_oeb11", OOeb, 11, 1, 0);
    tick(1);
    m_sda_o = 1'b1;
    expect_at("od_high_oeb9", OOeb, 9, 1, 0);
    expect_at("od_high_out9", OOut, 9, 0, 0);
    expect_at("pp_high_oeb9", OPpOeb, 9, 0, 0);
    expect_at("pp_high_out9", OPpOut, 9, 1, 0);
    tick(1);
    m_sda_oen = 1'b0;
    expect_at("od_rel_oeb9", OOeb, 9, 1, 0);
    expect_at("pp_rel_oeb9", OPpOeb, 9, 1, 0);
    tick(2);

    // Channel 1 START/STOP while ch0 stays quiet
    io_in[11] = 1'b0;
    expect_at("ch1_start1_d5", OStart, 1, 0, 5);
    expect_at("ch1_start1_d6", OStart, 1, 1, 6);
    expect_at("ch1_busy1_d6", OBusy, 1, 1, 6);
    expect_at("ch1_start0_d6", OStart, 0, 0, 6);
    expect_at("ch1_busy0_d6", OBusy, 0, 0, 6);
    expect_at("ch1_start1_d7", OStart, 1, 0, 7);
    tick(8);
    io_in[11] = 1'b1;
    expect_at("ch1_busy1_hold", OBusy, 1, 1, 5);
    expect_at("ch1_stop1_d6", OStop, 1, 1, 6);
    expect_at("ch1_busy1_clr", OBusy, 1, 0, 6);
    expect_at("ch1_stop0_d6", OStop, 0, 0, 6);
    expect_at("ch1_stop1_d7", OStop, 1, 0, 7);
    tick(10);

    // Switch request held while ch0 is busy
    io_in[9] = 1'b0;
    expect_at("sw_start0", OStart, 0, 1, 6);
    expect_at("sw_busy0", OBusy, 0, 1, 6);
    tick(7);
    sel = 1'b1;
    expect_at("sw_pend_a", OPend, 0, 1, 0);
    expect_at("sw_active_a", OActive, 0, 0, 0);
    expect_at("sw_pend_b", OPend, 0, 1, 3);
    expect_at("sw_active_b", OActive, 0, 0, 3);
    tick(3);
    io_in[9]  = 1'b1;
    io_in[10] = 1'b0;
    expect_at("sw_active_c", OActive, 0, 0, 5);
    expect_at("sw_pend_c", OPend, 0, 1, 5);
    expect_at("sw_stop0", OStop, 0, 1, 6);
    expect_at("sw_active_d", OActive, 0, 0, 6);
    expect_at("sw_mscl_ch0", OMscl, 0, 1, 6);
    expect_at("sw_active_e", OActive, 0, 1, 7);
    expect_at("sw_pend_e", OPend, 0, 0, 7);
    expect_at("sw_mscl_ch1", OMscl, 0, 0, 7);
    tick(7);
    m_sda_oen = 1'b1;
    m_sda_o   = 1'b0;
    m_scl_oen = 1'b1;
    m_scl_o   = 1'b0;
    expect_at("sw_oeb8", OOeb, 8, 1, 0);
    expect_at("sw_oeb9", OOeb, 9, 1, 0);
    expect_at("sw_oeb10", OOeb, 10, 0, 0);
    expect_at("sw_oeb11", OOeb, 11, 0, 0);
    tick(1);
    m_sda_oen = 1'b0;
    m_sda_o   = 1'b1;
    m_scl_oen = 1'b0;
    m_scl_o   = 1'b1;
    io_in[10] = 1'b1;
    sel       = 1'b0;
    expect_at("back_active", OActive, 0, 0, 1);
    tick(3);

    // Asynchronous reset while master pulls ch0 SDA low on a busy bus
    io_in[9] = 1'b0;
    expect_at("ar_busy0_set", OBusy, 0, 1, 6);
    tick(7);
    m_sda_oen = 1'b1;
    m_sda_o   = 1'b0;
    expect_at("ar_drive_oeb9", OOeb, 9, 0, 0);
    tick(1);
    rst_n = 1'b0;
    expect_at("ar_oeb9", OOeb, 9, 1, 0);
    expect_at("ar_oeb_all", OOebAll, 0, 1, 0);
    expect_at("ar_busy0_clr", OBusy, 0, 0, 0);
    expect_at("ar_msda", OMsda, 0, 1, 0);
    tick(2);
    rst_n     = 1'b1;
    m_sda_oen = 1'b0;
    m_sda_o   = 1'b1;
    io_in[9]  = 1'b1;
    tick(3);

    for (int i = 0; i < 200 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d checks left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
